// File: rtl/q_sys_msgdma_st_arbiter_pkg.sv
// Shared definitions for the two-source packet arbiter feeding the mSGDMA timing-adapter FIFO.
// Holds the FSM state encoding and the default downstream fill threshold.
package q_sys_msgdma_st_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

  localparam int FILL_THRESH_DEFAULT = 6;

  function automatic arb_state_t lock_state(input logic idx);
    return idx ? ST_LOCK1 : ST_LOCK0;
  endfunction

endpackage

// File: rtl/q_sys_msgdma_rr_pick.sv
// Two-way round-robin pick: when both request, the source that did not win last time is chosen.
module q_sys_msgdma_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  assign gnt = (&req) ? ~last : req[1];

endmodule

// File: rtl/q_sys_msgdma_st_arbiter.sv
// Packet-level arbiter merging two Avalon-ST sources into one registered output stage.
// A source stays locked from grant until its eop beat; fill-level throttling applies only between packets.
module q_sys_msgdma_st_arbiter
  import q_sys_msgdma_st_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int FILL_THRESH = FILL_THRESH_DEFAULT,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_sop,
  input  logic                  s0_eop,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_sop,
  input  logic                  s1_eop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_channel,
  input  logic [3:0]            fifo_fill_level,
  output logic [CNT_WIDTH-1:0]  pkt_count0,
  output logic [CNT_WIDTH-1:0]  pkt_count1
);

  arb_state_t            r_state;
  logic                  r_last;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_sop;
  logic                  r_out_eop;
  logic                  r_out_channel;
  logic [CNT_WIDTH-1:0]  r_cnt0;
  logic [CNT_WIDTH-1:0]  r_cnt1;

  logic [1:0]            w_req;
  logic                  w_gnt;
  logic                  w_room;
  logic                  w_slot;
  logic                  w_sel;
  logic                  w_acc;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_sop;
  logic                  w_eop;

  assign w_req  = {s1_valid, s0_valid};
  assign w_room = int'(fifo_fill_level) < FILL_THRESH;

  q_sys_msgdma_rr_pick u_pick (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_gnt)
  );

  // The output register can take a beat when empty or draining this cycle.
  assign w_slot   = !r_out_valid || out_ready;
  assign s0_ready = (r_state == ST_LOCK0) && w_slot;
  assign s1_ready = (r_state == ST_LOCK1) && w_slot;

  assign w_sel  = (r_state == ST_LOCK1);
  assign w_acc  = (s0_ready && s0_valid) || (s1_ready && s1_valid);
  assign w_data = w_sel ? s1_data : s0_data;
  assign w_sop  = w_sel ? s1_sop  : s0_sop;
  assign w_eop  = w_sel ? s1_eop  : s0_eop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_last        <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_sop     <= 1'b0;
      r_out_eop     <= 1'b0;
      r_out_channel <= 1'b0;
      r_cnt0        <= '0;
      r_cnt1        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_room && (|w_req)) begin
            r_state <= lock_state(w_gnt);
            r_last  <= w_gnt;
          end
        end
        ST_LOCK0: begin
          if (w_acc && w_eop) begin
            r_state <= ST_IDLE;
            r_cnt0  <= r_cnt0 + CNT_WIDTH'(1);
          end
        end
        ST_LOCK1: begin
          if (w_acc && w_eop) begin
            r_state <= ST_IDLE;
            r_cnt1  <= r_cnt1 + CNT_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_acc) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= w_data;
        r_out_sop     <= w_sop;
        r_out_eop     <= w_eop;
        r_out_channel <= w_sel;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_sop     = r_out_sop;
  assign out_eop     = r_out_eop;
  assign out_channel = r_out_channel;
  assign pkt_count0  = r_cnt0;
  assign pkt_count1  = r_cnt1;

endmodule
